imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction RAM port that the fetch stage reads (ram_ena / ram_wena / ram_indata, word address = pc[11:2]).
- Accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit MIPS instruction words.
- Writes each word into the instruction RAM at consecutive word addresses.
- Holds the CPU (cpu_hold) for the whole load so fetch never reads a partially written program.

Parameters:
ADDR_WIDTH, 10, instruction RAM word-address width (matches pc[11:2]).
CNT_WIDTH, 11, width of word_count / words_written (holds 0..2^ADDR_WIDTH).

Ports:
clk  in  1  system clock, all logic rising-edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
base_addr  in  ADDR_WIDTH  first word address, latched on start.
word_count  in  CNT_WIDTH  number of words to load, latched on start.
in_valid  in  1  byte-stream valid.
in_data  in  8  byte-stream data.
in_ready  out  1  loader can accept a byte.
ram_ena  out  1  instruction RAM enable for a write.
ram_wena  out  1  instruction RAM write enable.
ram_addr  out  ADDR_WIDTH  instruction RAM word address.
ram_indata  out  32  instruction word to write.
cpu_hold  out  1  stall PC/pipeline while high.
busy  out  1  state != IDLE.
done  out  1  one-cycle completion pulse.
words_written  out  CNT_WIDTH  words written in the current/last load.
checksum  out  32  mod-2^32 sum of words written in the current/last load.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; byte_idx=0, word_idx=0, assembly reg=0, words_written=0, checksum=0. All outputs 0.
- Reset mid-load: abort to IDLE, discard any partial word. Words already written stay in RAM.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - in_ready=0, cpu_hold=0.
  - On start: latch base_addr; latch min(word_count, 2^ADDR_WIDTH); clear words_written and checksum.
  - If the latched count is 0, go to DONE; otherwise go to RECV with byte_idx=0.
- RECV:
  - in_ready=1, cpu_hold=1.
  - A byte transfers on a cycle where in_valid && in_ready.
  - Packing is big-endian: byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - byte_idx increments 0..3. The transfer with byte_idx==3 moves to WRITE on the next edge.
  - in_valid=0 simply waits, with no timeout.
- WRITE (exactly one cycle):
  - in_ready=0. ram_ena=1, ram_wena=1.
  - ram_addr = (base + word_idx) mod 2^ADDR_WIDTH; the address wraps past the top of RAM.
  - ram_indata = assembled word.
  - At the edge: checksum += word (mod 2^32), words_written++, word_idx++.
  - If word_idx+1 == count go to DONE, else go to RECV with byte_idx=0.
- DONE (one cycle): done=1, cpu_hold=1, in_ready=0; then go to IDLE.
- Outside WRITE, ram_ena=ram_wena=0, ram_addr=0 and ram_indata=0.
- start while busy is ignored; base_addr and word_count are not re-sampled.
- Latency:
  - The RAM write occurs in the cycle after the 4th byte is accepted.
  - Minimum load time is 5 cycles per word (4 bytes + 1 write) plus 1 DONE cycle.
- words_written and checksum hold their values after DONE until the next start or reset.
- cpu_hold is asserted from the cycle after start through DONE inclusive.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> all outputs 0; start=0 keeps in_ready=0 and busy=0.
- Single word: start, base=0x010, count=1; bytes 0x3C,0x01,0x00,0x20 back-to-back -> one WRITE cycle with ram_addr=0x010 and ram_indata=0x3C010020; next cycle done=1; words_written=1; checksum=0x3C010020.
- Wrap and stalls: base=0x3FF, count=2; in_valid toggled every other cycle; words 0xFFFFFFFF, 0x00000002 -> addr 0x3FF then 0x000; checksum=0x00000001; no byte lost or duplicated.
- Zero count and saturation: count=0 -> DONE pulse 1 cycle after start with no RAM write; count=2047 -> latched as 1024 and exactly 1024 writes.
- Reset mid-load: rst asserted after 2 bytes of word 3 -> IDLE next edge; no write for word 3; first 2 words remain in RAM; words_written=0.
- start while busy: pulse start with base=0x100 during RECV -> ignored; the original base and count complete unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction RAM loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive word addresses while holding the CPU off fetch.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  ram_ena,
    output logic                  ram_wena,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_indata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  words_written,
    output logic [31:0]           checksum
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(1) << ADDR_WIDTH;

    state_t                state;
    logic [1:0]            byte_idx;
    logic [CNT_WIDTH-1:0]  word_idx;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           asm_q;
    logic [31:0]           asm_next;
    logic [CNT_WIDTH-1:0]  count_sat;

    // A load can never exceed the RAM size, so larger requests are clamped.
    always_comb begin
        count_sat = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
    end

    always_comb begin
        asm_next = asm_q;
        case (byte_idx)
            2'd0: asm_next[31:24] = in_data;
            2'd1: asm_next[23:16] = in_data;
            2'd2: asm_next[15:8]  = in_data;
            default: asm_next[7:0] = in_data;
        endcase
    end

    // Outputs are registered alongside the state so each one is valid for the
    // whole cycle the state it belongs to is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_idx      <= '0;
            word_idx      <= '0;
            count_q       <= '0;
            base_q        <= '0;
            asm_q         <= '0;
            words_written <= '0;
            checksum      <= '0;
            in_ready      <= 1'b0;
            ram_ena       <= 1'b0;
            ram_wena      <= 1'b0;
            ram_addr      <= '0;
            ram_indata    <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_addr;
                        count_q       <= count_sat;
                        words_written <= '0;
                        checksum      <= '0;
                        word_idx      <= '0;
                        byte_idx      <= '0;
                        busy          <= 1'b1;
                        cpu_hold      <= 1'b1;
                        if (count_sat == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RECV;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        asm_q    <= asm_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state      <= WRITE;
                            in_ready   <= 1'b0;
                            ram_ena    <= 1'b1;
                            ram_wena   <= 1'b1;
                            ram_addr   <= base_q + word_idx[ADDR_WIDTH-1:0];
                            ram_indata <= asm_next;
                        end
                    end
                end
                WRITE: begin
                    ram_ena       <= 1'b0;
                    ram_wena      <= 1'b0;
                    ram_addr      <= '0;
                    ram_indata    <= '0;
                    checksum      <= checksum + asm_q;
                    words_written <= words_written + CNT_WIDTH'(1);
                    word_idx      <= word_idx + CNT_WIDTH'(1);
                    if ((word_idx + CNT_WIDTH'(1)) == count_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RECV;
                        byte_idx <= '0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader, compared against a simple
// byte-list-to-word reference model and a shadow copy of the instruction RAM.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_ena;
    logic        ram_wena;
    logic [9:0]  ram_addr;
    logic [31:0] ram_indata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [10:0] words_written;
    logic [31:0] checksum;

    int total_checks  = 0;
    int passed_checks = 0;
    int cyc           = 0;
    int idle_viol     = 0;

    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] tb_ram [0:1023];
    logic [7:0]  tx_bytes[$];

    imem_loader #(.ADDR_WIDTH(10), .CNT_WIDTH(11)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_ena(ram_ena), .ram_wena(ram_wena),
        .ram_addr(ram_addr), .ram_indata(ram_indata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .words_written(words_written),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Shadow RAM: captures every write and flags RAM-port activity outside a write.
    always @(negedge clk) begin
        if (ram_ena && ram_wena) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_indata);
            tb_ram[ram_addr] = ram_indata;
        end else if (ram_ena || ram_wena || ram_addr != 10'd0 || ram_indata != 32'd0) begin
            idle_viol++;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed === expected) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    // Runs one load of tx_bytes (padded with random bytes) and checks it against the model.
    task automatic applyStimulus(input logic [9:0] base, input logic [10:0] count,
                                 input int stall_mode, input bit inject_start);
        int          eff;
        int          nbytes;
        int          idx;
        int          cycles;
        int          start_cyc;
        int          done_cyc;
        bit          v;
        bit          fire;
        logic [31:0] word;
        logic [31:0] sum;
        logic [9:0]  exp_addr;

        eff    = (count > 11'd1024) ? 1024 : int'(count);
        nbytes = eff * 4;
        while (tx_bytes.size() < nbytes) tx_bytes.push_back(8'($urandom));
        wr_addr_q.delete();
        wr_data_q.delete();

        @(negedge clk);
        base_addr  = base;
        word_count = count;
        start      = 1'b1;
        start_cyc  = cyc + 1;
        @(negedge clk);
        start      = 1'b0;
        base_addr  = 10'($urandom);
        word_count = 11'($urandom);
        checkOutput("cpu_hold_after_start", 32'(cpu_hold), 32'd1);
        checkOutput("busy_after_start", 32'(busy), 32'd1);

        done_cyc = -1;
        if (done) done_cyc = cyc;
        idx    = 0;
        cycles = 0;
        while (idx < nbytes && cycles < nbytes * 4 + 100) begin
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = tx_bytes[idx];
            if (inject_start && cycles == 3) begin
                start      = 1'b1;
                base_addr  = 10'h100;
                word_count = 11'd7;
            end else begin
                start = 1'b0;
            end
            fire = v && in_ready;
            @(negedge clk);
            cycles++;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checkOutput("bytes_accepted", 32'(idx), 32'(nbytes));

        for (int k = 0; k < 20 && done_cyc < 0; k++) begin
            if (done) done_cyc = cyc;
            else @(negedge clk);
        end
        checkOutput("done_seen", 32'(done_cyc >= 0), 32'd1);
        checkOutput("cpu_hold_in_done", 32'(cpu_hold), 32'd1);
        if (stall_mode == 0 && !inject_start)
            checkOutput("load_latency", 32'(done_cyc - start_cyc), 32'(5 * eff));

        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_cleared", 32'(busy), 32'd0);
        checkOutput("cpu_hold_cleared", 32'(cpu_hold), 32'd0);

        checkOutput("write_count", 32'(wr_addr_q.size()), 32'(eff));
        sum = 32'd0;
        for (int i = 0; i < eff; i++) begin
            word     = {tx_bytes[4*i], tx_bytes[4*i+1], tx_bytes[4*i+2], tx_bytes[4*i+3]};
            sum      = sum + word;
            exp_addr = 10'((int'(base) + i) % 1024);
            if (i < wr_addr_q.size()) begin
                checkOutput("write_addr", 32'(wr_addr_q[i]), 32'(exp_addr));
                checkOutput("write_data", wr_data_q[i], word);
            end
        end
        checkOutput("words_written", 32'(words_written), 32'(eff));
        checkOutput("checksum", checksum, sum);
        tx_bytes.delete();
    endtask

    initial begin
        int          idx;
        int          cycles;
        bit          fire;
        logic [31:0] w0;
        logic [31:0] w1;

        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({in_ready, ram_ena, ram_wena, cpu_hold, busy, done}), 32'd0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset_ram_indata", ram_indata, 32'd0);
        checkOutput("reset_words_written", 32'(words_written), 32'd0);
        checkOutput("reset_checksum", checksum, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        tx_bytes = '{8'h3C, 8'h01, 8'h00, 8'h20};
        applyStimulus(10'h010, 11'd1, 0, 1'b0);

        tx_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
        applyStimulus(10'h3FF, 11'd2, 1, 1'b0);
        checkOutput("wrap_checksum_const", checksum, 32'h0000_0001);

        applyStimulus(10'($urandom), 11'd0, 0, 1'b0);

        for (int r = 0; r < 4; r++)
            applyStimulus(10'($urandom), 11'($urandom_range(1, 6)), 2, 1'b0);

        applyStimulus(10'h020, 11'd3, 0, 1'b1);

        applyStimulus(10'h155, 11'd2047, 0, 1'b0);

        // Abort mid-load: two full words plus two bytes of the third, then reset.
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 10; i++) tx_bytes.push_back(8'($urandom));
        @(negedge clk);
        base_addr  = 10'h200;
        word_count = 11'd5;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        idx    = 0;
        cycles = 0;
        while (idx < 10 && cycles < 100) begin
            in_valid = 1'b1;
            in_data  = tx_bytes[idx];
            fire     = in_ready;
            @(negedge clk);
            cycles++;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w0  = {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3]};
        w1  = {tx_bytes[4], tx_bytes[5], tx_bytes[6], tx_bytes[7]};
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("abort_words_written", 32'(words_written), 32'd0);
        checkOutput("abort_checksum", checksum, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("abort_write_count", 32'(wr_addr_q.size()), 32'd2);
        checkOutput("abort_ram_word0", tb_ram[10'h200], w0);
        checkOutput("abort_ram_word1", tb_ram[10'h201], w1);
        tx_bytes.delete();

        checkOutput("ram_port_idle_clean", 32'(idle_viol), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
